// File: rtl/pc_ras.sv
// Fetch-stage program counter: sequential/absolute/relative branches, call/return
// through a circular return-address stack, stall, and a sticky halt state.
module pc_ras #(
  parameter int unsigned   D         = 12,
  parameter int unsigned   OFF_W     = 8,
  parameter int unsigned   RAS_DEPTH = 4,
  parameter logic [D-1:0]  RESET_VEC = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic                               jcnd,
  input  logic [2:0]                         branch,
  input  logic [D-1:0]                       target,
  input  logic [OFF_W-1:0]                   offset,
  output logic [D-1:0]                       prog_ctr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_cnt,
  output logic                               ras_ovf,
  output logic                               ras_unf,
  output logic                               halted
);

  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam int unsigned PW = $clog2(RAS_DEPTH);

  localparam logic [2:0] BR_SEQ  = 3'b000;
  localparam logic [2:0] BR_ABS  = 3'b001;
  localparam logic [2:0] BR_JMP  = 3'b010;
  localparam logic [2:0] BR_REL  = 3'b011;
  localparam logic [2:0] BR_JREL = 3'b100;
  localparam logic [2:0] BR_CALL = 3'b101;
  localparam logic [2:0] BR_RET  = 3'b110;
  localparam logic [2:0] BR_HALT = 3'b111;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t          state;
  logic [D-1:0]    ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ras_top;

  logic [D-1:0]    pc_inc;
  logic [D-1:0]    pc_rel;
  logic [D-1:0]    pc_nxt;
  logic [PW-1:0]   top_inc;
  logic            ras_full;
  logic            ras_empty;
  logic            do_push;
  logic            do_pop;
  logic            set_ovf;
  logic            set_unf;
  logic            go_halt;

  // Candidate next-PC values; offset is sign-extended to the PC width.
  always_comb begin
    pc_inc    = prog_ctr + D'(1);
    pc_rel    = prog_ctr + D'($signed(offset));
    top_inc   = ras_top + PW'(1);
    ras_full  = (ras_cnt == CW'(RAS_DEPTH));
    ras_empty = (ras_cnt == '0);
  end

  // Command decode; defaults hold everything, so stall and HALT fall through.
  always_comb begin
    pc_nxt  = prog_ctr;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    go_halt = 1'b0;
    if (state == S_RUN && !stall) begin
      case (branch)
        BR_SEQ:  pc_nxt = pc_inc;
        BR_ABS:  pc_nxt = jcnd ? target : pc_inc;
        BR_JMP:  pc_nxt = target;
        BR_REL:  pc_nxt = jcnd ? pc_rel : pc_inc;
        BR_JREL: pc_nxt = pc_rel;
        BR_CALL: begin
          pc_nxt  = target;
          do_push = 1'b1;
          set_ovf = ras_full;
        end
        BR_RET: begin
          if (ras_empty) begin
            pc_nxt  = pc_inc;
            set_unf = 1'b1;
          end else begin
            pc_nxt = ras_mem[ras_top];
            do_pop = 1'b1;
          end
        end
        BR_HALT: go_halt = 1'b1;
        default: pc_nxt = prog_ctr;
      endcase
    end
  end

  // Control state, PC, stack pointer/count and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RUN;
      prog_ctr <= RESET_VEC;
      ras_top  <= '0;
      ras_cnt  <= '0;
      ras_ovf  <= 1'b0;
      ras_unf  <= 1'b0;
      halted   <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          prog_ctr <= pc_nxt;
          if (do_push) begin
            ras_top <= top_inc;
            if (!ras_full) ras_cnt <= ras_cnt + CW'(1);
          end else if (do_pop) begin
            ras_top <= ras_top - PW'(1);
            ras_cnt <= ras_cnt - CW'(1);
          end
          if (set_ovf) ras_ovf <= 1'b1;
          if (set_unf) ras_unf <= 1'b1;
          if (go_halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end
        end
        S_HALT: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
        default: state <= S_RUN;
      endcase
    end
  end

  // Stack storage; a push when full lands on the oldest slot because the pointer wraps.
  always_ff @(posedge clk) begin
    if (do_push) ras_mem[top_inc] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_ras.sv
// Directed table-driven bench for pc_ras, plus hand sequences for reset corners.
module tb_pc_ras;

  localparam int unsigned D  = 12;
  localparam int unsigned OW = 8;
  localparam int unsigned CW = 3;

  localparam logic [2:0] SEQ = 3'd0, BABS = 3'd1, JMP = 3'd2, BREL = 3'd3;
  localparam logic [2:0] JREL = 3'd4, CALL = 3'd5, RET = 3'd6, HLT = 3'd7;

  logic          clk;
  logic          reset;
  logic          stall;
  logic          jcnd;
  logic [2:0]    branch;
  logic [D-1:0]  target;
  logic [OW-1:0] offset;
  logic [D-1:0]  prog_ctr;
  logic [CW-1:0] ras_cnt;
  logic          ras_ovf;
  logic          ras_unf;
  logic          halted;

  pc_ras #(.D(D), .OFF_W(OW), .RAS_DEPTH(4), .RESET_VEC('0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jcnd(jcnd), .branch(branch),
    .target(target), .offset(offset), .prog_ctr(prog_ctr), .ras_cnt(ras_cnt),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          stl;
    logic          jc;
    logic [2:0]    br;
    logic [D-1:0]  tgt;
    logic [OW-1:0] off;
    logic [D-1:0]  e_pc;
    logic [CW-1:0] e_cnt;
    logic          e_ovf;
    logic          e_unf;
    logic          e_hlt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic rst, input logic stl, input logic jc, input logic [2:0] br,
                     input logic [D-1:0] tgt, input logic [OW-1:0] off, input logic [D-1:0] e_pc,
                     input logic [CW-1:0] e_cnt, input logic e_ovf, input logic e_unf,
                     input logic e_hlt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.jc = jc; v.br = br; v.tgt = tgt; v.off = off;
    v.e_pc = e_pc; v.e_cnt = e_cnt; v.e_ovf = e_ovf; v.e_unf = e_unf; v.e_hlt = e_hlt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [D-1:0] e_pc, input logic [CW-1:0] e_cnt,
                       input logic e_ovf, input logic e_unf, input logic e_hlt);
    n_vec++;
    if (prog_ctr !== e_pc || ras_cnt !== e_cnt || ras_ovf !== e_ovf ||
        ras_unf !== e_unf || halted !== e_hlt) begin
      n_err++;
      $display("FAIL %s: got pc=%h cnt=%0d ovf=%b unf=%b hlt=%b, want pc=%h cnt=%0d ovf=%b unf=%b hlt=%b",
               name, prog_ctr, ras_cnt, ras_ovf, ras_unf, halted,
               e_pc, e_cnt, e_ovf, e_unf, e_hlt);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // SEQ count from reset
    for (int k = 1; k <= 9; k++) add(0, 0, 0, SEQ, 12'h000, 8'h00, D'(k), 0, 0, 0, 0);
    // conditional absolute / relative branches
    add(0, 0, 0, BABS, 12'h020, 8'h00, 12'h00A, 0, 0, 0, 0);
    add(0, 0, 1, BABS, 12'h020, 8'h00, 12'h020, 0, 0, 0, 0);
    add(0, 0, 1, BREL, 12'h000, 8'hFC, 12'h01C, 0, 0, 0, 0);
    add(0, 0, 0, BREL, 12'h000, 8'hFC, 12'h01D, 0, 0, 0, 0);
    // wrap in both directions
    add(0, 0, 0, JMP,  12'hFFE, 8'h00, 12'hFFE, 0, 0, 0, 0);
    add(0, 0, 0, JREL, 12'h000, 8'h05, 12'h003, 0, 0, 0, 0);
    add(0, 0, 0, JMP,  12'hFFF, 8'h00, 12'hFFF, 0, 0, 0, 0);
    add(0, 0, 0, SEQ,  12'h000, 8'h00, 12'h000, 0, 0, 0, 0);
    add(0, 0, 0, JREL, 12'h000, 8'h80, 12'hF80, 0, 0, 0, 0);
    // single call/return
    add(0, 0, 0, JMP,  12'h010, 8'h00, 12'h010, 0, 0, 0, 0);
    add(0, 0, 0, CALL, 12'h100, 8'h00, 12'h100, 1, 0, 0, 0);
    add(0, 0, 1, RET,  12'h777, 8'h33, 12'h011, 0, 0, 0, 0);
    // nested calls with overflow, LIFO returns, underflow
    add(0, 0, 0, CALL, 12'h200, 8'h00, 12'h200, 1, 0, 0, 0);
    add(0, 0, 0, CALL, 12'h300, 8'h00, 12'h300, 2, 0, 0, 0);
    add(0, 0, 0, CALL, 12'h400, 8'h00, 12'h400, 3, 0, 0, 0);
    add(0, 0, 0, CALL, 12'h500, 8'h00, 12'h500, 4, 0, 0, 0);
    add(0, 0, 0, CALL, 12'h600, 8'h00, 12'h600, 4, 1, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h501, 3, 1, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h401, 2, 1, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h301, 1, 1, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h201, 0, 1, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h202, 0, 1, 1, 0);
    // stall beats every command
    for (int k = 0; k < 3; k++) add(0, 1, 1, JMP, 12'h055, 8'h00, 12'h202, 0, 1, 1, 0);
    add(0, 1, 0, CALL, 12'h077, 8'h00, 12'h202, 0, 1, 1, 0);
    add(0, 0, 0, JMP,  12'h055, 8'h00, 12'h055, 0, 1, 1, 0);
    // halt freezes everything
    add(0, 0, 0, HLT,  12'h000, 8'h00, 12'h055, 0, 1, 1, 1);
    add(0, 0, 1, JMP,  12'h123, 8'h00, 12'h055, 0, 1, 1, 1);
    add(0, 0, 0, CALL, 12'h007, 8'h00, 12'h055, 0, 1, 1, 1);
    add(0, 0, 0, SEQ,  12'h000, 8'h00, 12'h055, 0, 1, 1, 1);
    // reset leaves halt and clears flags
    add(1, 0, 0, SEQ,  12'h000, 8'h00, 12'h000, 0, 0, 0, 0);
    add(0, 0, 0, SEQ,  12'h000, 8'h00, 12'h001, 0, 0, 0, 0);
    add(0, 0, 0, RET,  12'h000, 8'h00, 12'h002, 0, 0, 1, 0);

    reset = 1'b1; stall = 1'b0; jcnd = 1'b0; branch = SEQ; target = '0; offset = '0;
    repeat (2) @(negedge clk);
    check("reset_state", 12'h000, 0, 0, 0, 0);
    reset = 1'b0;

    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("pre_seq", D'(k), 0, 0, 0, 0);
    end
    // asynchronous reset between edges
    #2 reset = 1'b1;
    #1 check("async_reset", 12'h000, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      stall  = vecs[i].stl;
      jcnd   = vecs[i].jc;
      branch = vecs[i].br;
      target = vecs[i].tgt;
      offset = vecs[i].off;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_cnt,
            vecs[i].e_ovf, vecs[i].e_unf, vecs[i].e_hlt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
